// File: rtl/b_er_frame_scheduler_pkg.sv
// b_er_frame_scheduler_pkg: shared sizing constants and state encoding for Bob's frame scheduler
package b_er_frame_scheduler_pkg;
    localparam int FRAME_NUM_DEF   = 16;
    localparam int FRAME_WORDS_DEF = 1024;
    localparam int TIMEOUT_CYC_DEF = 2**22;
    localparam int HALF_WORDS      = 16384;
    localparam int HALF_SH         = $clog2(HALF_WORDS);
    localparam int ADDR_W          = HALF_SH + 1;
    typedef enum logic [2:0] {
        IDLE, LATCH, ISSUE, WAIT_DONE, RECORD, NEXT, FINISH
    } state_t;
endpackage

// File: rtl/b_er_frame_scheduler_watchdog.sv
// er_frame_watchdog: loadable up-counter that saturates and flags expiry at TIMEOUT_CYC-1
module er_frame_watchdog #(
    parameter int TIMEOUT_CYC = 2**22,
    localparam int W = $clog2(TIMEOUT_CYC)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;
    assign expired = count == W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !expired)
            count <= count + 1'b1;
endmodule

// File: rtl/b_er_frame_scheduler.sv
// b_er_frame_scheduler: walks every frame of one sifted-key half through the single-frame ER engine
module b_er_frame_scheduler
    import b_er_frame_scheduler_pkg::*;
#(
    parameter int FRAME_NUM   = FRAME_NUM_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IW  = $clog2(FRAME_NUM),
    localparam int CW  = $clog2(FRAME_NUM + 1),
    localparam int WSH = $clog2(FRAME_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_all_frame_er,
    input  logic              sifted_key_addr_index,
    input  logic              B_B2A_full,
    input  logic              single_frame_done,
    input  logic              single_frame_ev_fail,
    output logic              start_single_frame,
    output logic              abort_single_frame,
    output logic [ADDR_W-1:0] frame_base_addr,
    output logic [IW-1:0]     frame_idx,
    output logic [FRAME_NUM-1:0] frame_fail_bitmap,
    output logic [CW-1:0]     frame_fail_cnt,
    output logic              timeout_err,
    output logic              busy,
    output logic              finish_all_frame_er
);
    state_t state, next_state;
    logic idx_lat, fail_r, expired, last;
    logic start_d, abort_d, finish_d, busy_d, tmo_d, lat_d, fail_d;
    logic [ADDR_W-1:0] base_d;
    logic [IW-1:0] idx_d;
    logic [FRAME_NUM-1:0] bm_d;
    logic [CW-1:0] cnt_d;

    function automatic logic [ADDR_W-1:0] base_of(input logic half, input logic [IW-1:0] i);
        return {half, {HALF_SH{1'b0}}} + (ADDR_W'(i) << WSH);
    endfunction

    assign last = frame_idx == IW'(FRAME_NUM - 1);

    er_frame_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ISSUE && start_single_frame),
        .en       (state == WAIT_DONE),
        .load     (1'b0),
        .load_val ('0),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = start_all_frame_er ? LATCH : IDLE;
            LATCH:     next_state = ISSUE;
            ISSUE:     next_state = start_single_frame ? WAIT_DONE : ISSUE;
            WAIT_DONE: next_state = (single_frame_done || expired) ? RECORD : WAIT_DONE;
            RECORD:    next_state = NEXT;
            NEXT:      next_state = last ? FINISH : ISSUE;
            default:   next_state = IDLE;
        endcase
    end

    // The issue decision is taken one cycle early so the start pulse coincides with ISSUE.
    always_comb begin
        start_d  = next_state == ISSUE && !B_B2A_full;
        abort_d  = state == WAIT_DONE && !single_frame_done && expired;
        finish_d = next_state == FINISH;
        busy_d   = next_state != IDLE;
        lat_d    = idx_lat;
        idx_d    = frame_idx;
        base_d   = frame_base_addr;
        bm_d     = frame_fail_bitmap;
        cnt_d    = frame_fail_cnt;
        tmo_d    = timeout_err;
        fail_d   = fail_r;
        case (state)
            IDLE: if (start_all_frame_er) begin
                lat_d = sifted_key_addr_index;
                idx_d = '0;
                bm_d  = '0;
                cnt_d = '0;
                tmo_d = 1'b0;
            end
            LATCH: base_d = base_of(idx_lat, frame_idx);
            WAIT_DONE: begin
                fail_d = single_frame_done ? single_frame_ev_fail : expired ? 1'b1 : fail_r;
                tmo_d  = timeout_err | abort_d;
            end
            RECORD: if (fail_r) begin
                bm_d[frame_idx] = 1'b1;
                cnt_d = frame_fail_cnt == CW'(FRAME_NUM) ? frame_fail_cnt : frame_fail_cnt + 1'b1;
            end
            NEXT: if (!last) begin
                idx_d  = frame_idx + 1'b1;
                base_d = base_of(idx_lat, frame_idx + 1'b1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            start_single_frame  <= 1'b0;
            abort_single_frame  <= 1'b0;
            finish_all_frame_er <= 1'b0;
            busy                <= 1'b0;
            idx_lat             <= 1'b0;
            fail_r              <= 1'b0;
            frame_idx           <= '0;
            frame_base_addr     <= '0;
            frame_fail_bitmap   <= '0;
            frame_fail_cnt      <= '0;
            timeout_err         <= 1'b0;
        end else begin
            start_single_frame  <= start_d;
            abort_single_frame  <= abort_d;
            finish_all_frame_er <= finish_d;
            busy                <= busy_d;
            idx_lat             <= lat_d;
            fail_r              <= fail_d;
            frame_idx           <= idx_d;
            frame_base_addr     <= base_d;
            frame_fail_bitmap   <= bm_d;
            frame_fail_cnt      <= cnt_d;
            timeout_err         <= tmo_d;
        end
endmodule

// File: tb/tb_b_er_frame_scheduler.sv
// tb_b_er_frame_scheduler: directed runs against a behavioural frame-engine responder
module tb_b_er_frame_scheduler;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start_all_frame_er = 1'b0, sifted_key_addr_index = 1'b0, B_B2A_full = 1'b0;
    logic single_frame_done = 1'b0, single_frame_ev_fail = 1'b0;
    logic start_single_frame, abort_single_frame, timeout_err, busy, finish_all_frame_er;
    logic [14:0] frame_base_addr;
    logic [3:0] frame_idx;
    logic [15:0] frame_fail_bitmap;
    logic [4:0] frame_fail_cnt;

    b_er_frame_scheduler #(.FRAME_NUM(16), .FRAME_WORDS(1024), .TIMEOUT_CYC(64)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_all_frame_er    (start_all_frame_er),
        .sifted_key_addr_index (sifted_key_addr_index),
        .B_B2A_full            (B_B2A_full),
        .single_frame_done     (single_frame_done),
        .single_frame_ev_fail  (single_frame_ev_fail),
        .start_single_frame    (start_single_frame),
        .abort_single_frame    (abort_single_frame),
        .frame_base_addr       (frame_base_addr),
        .frame_idx             (frame_idx),
        .frame_fail_bitmap     (frame_fail_bitmap),
        .frame_fail_cnt        (frame_fail_cnt),
        .timeout_err           (timeout_err),
        .busy                  (busy),
        .finish_all_frame_er   (finish_all_frame_er)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    int resp_delay = 10;
    logic [15:0] fail_mask = '0, hang_mask = '0;
    logic stray_en = 1'b0;
    int st_cyc[256], st_base[256], st_idx[256];
    int n_st = 0, n_ab = 0, n_fin = 0, ab_cyc = 0;
    int c0, b0, a0, f0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (start_single_frame) begin
            st_cyc[n_st] = cyc;
            st_base[n_st] = int'(frame_base_addr);
            st_idx[n_st] = int'(frame_idx);
            n_st++;
        end
        if (abort_single_frame) begin
            ab_cyc = cyc;
            n_ab++;
        end
        if (finish_all_frame_er) n_fin++;
    end

    // Frame engine model: answers resp_delay cycles after each start unless the frame is set to hang.
    initial begin
        int cd = 0;
        logic [3:0] cur = '0;
        logic sp = 1'b0;
        forever begin
            @(negedge clk);
            single_frame_done = 1'b0;
            single_frame_ev_fail = 1'b0;
            if (!rst_n) begin
                cd = 0;
                sp = 1'b0;
            end else if (start_single_frame) begin
                cur = frame_idx;
                cd = hang_mask[cur] ? 0 : resp_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    single_frame_done = 1'b1;
                    single_frame_ev_fail = fail_mask[cur];
                    sp = stray_en;
                end
            end else if (sp) begin
                single_frame_done = 1'b1;
                single_frame_ev_fail = 1'b1;
                sp = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input logic ix);
        b0 = n_st; a0 = n_ab; f0 = n_fin;
        sifted_key_addr_index = ix;
        start_all_frame_er = 1'b1;
        c0 = cyc;
        tick(1);
        start_all_frame_er = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        int k = 0;
        while (!finish_all_frame_er && k < budget) begin
            tick(1);
            k++;
        end
        chk("run_ends", 32'(k < budget), 1);
        tick(3);
    endtask

    task automatic zero_chk(input string t);
        chk({t, "_start"}, start_single_frame, 0);
        chk({t, "_abort"}, abort_single_frame, 0);
        chk({t, "_base"}, frame_base_addr, 0);
        chk({t, "_idx"}, frame_idx, 0);
        chk({t, "_bitmap"}, frame_fail_bitmap, 0);
        chk({t, "_cnt"}, frame_fail_cnt, 0);
        chk({t, "_tmo"}, timeout_err, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_finish"}, finish_all_frame_er, 0);
    endtask

    task automatic run_chk(input string t, input int half, input logic [15:0] bm, input int cnt, input logic tmo);
        int bad = 0;
        chk({t, "_nstart"}, n_st - b0, 16);
        for (int i = 0; i < 16; i++)
            if (st_base[b0 + i] != half * 16384 + i * 1024 || st_idx[b0 + i] != i) bad++;
        chk({t, "_base0"}, st_base[b0], half * 16384);
        chk({t, "_bases_bad"}, bad, 0);
        chk({t, "_bitmap"}, frame_fail_bitmap, bm);
        chk({t, "_cnt"}, frame_fail_cnt, cnt);
        chk({t, "_tmo"}, timeout_err, tmo);
        chk({t, "_nfinish"}, n_fin - f0, 1);
        chk({t, "_busy_end"}, busy, 0);
        chk({t, "_idx_hold"}, frame_idx, 15);
        chk({t, "_base_hold"}, frame_base_addr, half * 16384 + 15360);
    endtask

    initial begin
        int k;
        tick(3);
        zero_chk("rst");
        rst_n = 1'b1;
        tick(2);

        go(1'b0);
        chk("busy_run", busy, 1);
        wait_fin(2000);
        run_chk("nom", 0, 16'h0000, 0, 1'b0);
        chk("nom_latency", st_cyc[b0] - c0, 2);
        chk("nom_done_to_start", st_cyc[b0 + 1] - st_cyc[b0], 13);
        chk("nom_aborts", n_ab - a0, 0);

        fail_mask = 16'h8008;
        stray_en = 1'b1;
        go(1'b1);
        tick(5);
        sifted_key_addr_index = 1'b0;
        tick(20);
        start_all_frame_er = 1'b1;
        tick(1);
        start_all_frame_er = 1'b0;
        wait_fin(2000);
        run_chk("upper", 1, 16'h8008, 2, 1'b0);
        stray_en = 1'b0;
        fail_mask = '0;

        resp_delay = 5;
        B_B2A_full = 1'b1;
        go(1'b0);
        tick(51);
        chk("bp_hold", n_st - b0, 0);
        B_B2A_full = 1'b0;
        k = cyc;
        wait_fin(2000);
        chk("bp_release", st_cyc[b0] - k, 1);
        run_chk("bp", 0, 16'h0000, 0, 1'b0);

        resp_delay = 10;
        hang_mask = 16'h0020;
        go(1'b0);
        wait_fin(3000);
        hang_mask = '0;
        run_chk("wdog", 0, 16'h0020, 1, 1'b1);
        chk("wdog_aborts", n_ab - a0, 1);
        chk("wdog_abort_cyc", ab_cyc - st_cyc[b0 + 5], 65);
        chk("wdog_resume", st_cyc[b0 + 6] - st_cyc[b0 + 5], 67);

        resp_delay = 64;
        go(1'b0);
        wait_fin(3000);
        run_chk("tie", 0, 16'h0000, 0, 1'b0);
        chk("tie_aborts", n_ab - a0, 0);

        resp_delay = 10;
        go(1'b1);
        k = 0;
        while (!(start_single_frame && frame_idx == 4'd7) && k < 1000) begin
            tick(1);
            k++;
        end
        chk("f7_reached", 32'(k < 1000), 1);
        tick(3);
        rst_n = 1'b0;
        #1;
        zero_chk("midrst");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        fail_mask = 16'hffff;
        go(1'b0);
        wait_fin(2000);
        run_chk("fresh", 0, 16'hffff, 16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
